alu_mult_sequencer: RTL and testbench

//   Multi-cycle controller that performs 32x32 unsigned multiply (MULTU) by

---
 rtl/alu_mult_sequencer.sv | 112 +++++++++++
 tb/tb_alu_mult_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Sequences the shared 32-bit ALU through 32 shift-add steps to form a 32x32 unsigned product.
// Latency: start sampled at edge N, done pulses in the cycle after edge N+32; one multiply per 34 cycles.
// Backpressure: none; busy stalls the pipeline, and start is ignored outside IDLE.
module alu_mult_sequencer #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [3:0]  ALU_ADD_OP  = 4'b0011,
  parameter logic [3:0]  ALU_IDLE_OP = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the final shift-add step; the count register wraps past it harmlessly.
  localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [5:0]            count_q;

  logic [DATA_WIDTH-1:0] hi_d;
  logic [DATA_WIDTH-1:0] lo_d;
  logic                  carry;

  // One shift-add step: the ALU adds the (possibly zero) multiplicand into hi;
  // the add's carry-out is recovered by an unsigned compare and shifted into hi,
  // while the sum's LSB shifts into the top of lo.
  always_comb begin
    carry = (alu_result < hi_q);
    hi_d  = {carry, alu_result[DATA_WIDTH-1:1]};
    lo_d  = {alu_result[0], lo_q[DATA_WIDTH-1:1]};
  end

  // Controller state and product datapath; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q <= multiplicand;
            hi_q    <= '0;
            lo_q    <= multiplier;
            count_q <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + 6'd1;
          if (count_q == LAST_ITER) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags are straight decodes of the registered state.
  always_comb begin
    busy = (state_q == S_ITER);
    done = (state_q == S_DONE);
  end

  // The ALU is only borrowed while iterating; otherwise it sees a benign AND of zeros.
  always_comb begin
    alu_op    = ALU_IDLE_OP;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = 5'd0;
    if (state_q == S_ITER) begin
      alu_op = ALU_ADD_OP;
      alu_a  = hi_q;
      alu_b  = lo_q[0] ? mcand_q : '0;
    end
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer with a behavioural ALU and a
// plain 64-bit multiply as the reference for every product.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;

  int total;
  int bad;

  alu_mult_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result)
  );

  // Shared ALU: ADD for opcode 0011, AND otherwise.
  assign alu_result = (alu_op == 4'b0011) ? (alu_a + alu_b) : (alu_a & alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply and watch it to completion (bounded).
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat,
                         output int busy_n, output int alu_err,
                         output logic done_after);
    lat = -1; busy_n = 0; alu_err = 0; prod = '0; done_after = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk);
    #1;
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_n++;
        if (alu_op !== 4'b0011 || alu_shamt !== 5'd0) alu_err++;
        if (alu_b !== 32'd0 && alu_b !== a) alu_err++;
      end else if (alu_op !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_shamt !== 5'd0) begin
        alu_err++;
      end
      if (done === 1'b1) begin
        lat  = k;
        prod = {product_hi, product_lo};
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || {product_hi, product_lo} !== 64'd0 ||
          alu_op !== 4'b0000 || alu_shamt !== 5'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b prod=%h op=%h shamt=%0d want 0 0 0 0 0",
                 i, busy, done, {product_hi, product_lo}, alu_op, alu_shamt);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    logic [63:0] prod;
    int lat, busy_n, alu_err;
    logic done_after;
    ta[0] = 32'd3;         tb[0] = 32'd5;         te[0] = 64'h0000_0000_0000_000F;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF; te[1] = 64'hFFFF_FFFE_0000_0001;
    ta[2] = 32'h8000_0000; tb[2] = 32'd2;         te[2] = 64'h0000_0001_0000_0000;
    ta[3] = 32'd0;         tb[3] = 32'h1234_5678; te[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      do_mult(ta[i], tb[i], prod, lat, busy_n, alu_err, done_after);
      total++;
      if (prod !== te[i]) begin
        bad++;
        $display("FAIL directed_prod %h*%h got %h want %h", ta[i], tb[i], prod, te[i]);
      end
      total++;
      if (lat !== 33 || busy_n !== 32) begin
        bad++;
        $display("FAIL directed_timing %h*%h got lat=%0d busy=%0d want lat=33 busy=32", ta[i], tb[i], lat, busy_n);
      end
      total++;
      if (alu_err !== 0 || done_after !== 1'b0) begin
        bad++;
        $display("FAIL directed_alu_pulse %h*%h got alu_err=%0d done_after=%b want 0 0", ta[i], tb[i], alu_err, done_after);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] prod, exp;
    int lat, busy_n, alu_err;
    logic done_after;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom;
      if (i % 4 == 1) a = a | 32'hFFFF_0000;
      if (i % 4 == 2) b = b & 32'h0000_00FF;
      exp = 64'(a) * 64'(b);
      do_mult(a, b, prod, lat, busy_n, alu_err, done_after);
      total++;
      if (prod !== exp || lat !== 33 || alu_err !== 0 || done_after !== 1'b0) begin
        bad++;
        $display("FAIL random %h*%h got prod=%h lat=%0d alu_err=%0d done_after=%b want prod=%h lat=33 0 0",
                 a, b, prod, lat, alu_err, done_after, exp);
      end
    end
  endtask

  task automatic test_ignore_restart();
    logic [31:0] a, b;
    logic [63:0] prod, exp;
    int dones, lat;
    a = 32'h1234_ABCD; b = 32'h0BAD_F00D;
    exp = 64'(a) * 64'(b);
    dones = 0; lat = -1; prod = '0;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 10) begin
        start = 1'b1; multiplicand = 32'h7; multiplier = 32'h9;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat  = k;
          prod = {product_hi, product_lo};
        end
      end
    end
    total++;
    if (dones !== 1 || lat !== 33) begin
      bad++;
      $display("FAIL restart_pulses got dones=%0d lat=%0d want 1 33", dones, lat);
    end
    total++;
    if (prod !== exp) begin
      bad++;
      $display("FAIL restart_prod got %h want %h", prod, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] prod;
    int lat, busy_n, alu_err, dones;
    logic done_after;
    @(negedge clk);
    start = 1'b1; multiplicand = 32'hDEAD_BEEF; multiplier = 32'hCAFE_1234;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {product_hi, product_lo} !== 64'd0 || alu_op !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_state got busy=%b done=%b prod=%h op=%h want 0 0 0 0",
               busy, done, {product_hi, product_lo}, alu_op);
    end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got active_cycles=%0d want 0", dones);
    end
    do_mult(32'd7, 32'd6, prod, lat, busy_n, alu_err, done_after);
    total++;
    if (prod !== 64'd42 || lat !== 33) begin
      bad++;
      $display("FAIL reset_mid_restart got prod=%h lat=%0d want 2a 33", prod, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] p1, p2;
    int t1, t2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    t1 = -1; t2 = -1; p1 = '0; p2 = '0;
    @(negedge clk);
    start = 1'b1; multiplicand = a1; multiplier = b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (t1 < 0) begin
          t1 = k; p1 = {product_hi, product_lo};
          multiplicand = a2; multiplier = b2;
        end else begin
          t2 = k; p2 = {product_hi, product_lo};
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    total++;
    if (t1 < 0 || t2 - t1 !== 34) begin
      bad++;
      $display("FAIL b2b_spacing got first=%0d second=%0d want gap 34", t1, t2);
    end
    total++;
    if (p1 !== 64'(a1) * 64'(b1) || p2 !== 64'(a2) * 64'(b2)) begin
      bad++;
      $display("FAIL b2b_prod got %h %h want %h %h", p1, p2, 64'(a1) * 64'(b1), 64'(a2) * 64'(b2));
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_restart();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
